// File: rtl/afifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
// Optional AFIFO_ARB_STATS_EN adds saturating stall_cnt / grant_cnt outputs.
module afifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            wclk,
    input  logic                            wrst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            winc,
    output logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            wfull,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
`ifdef AFIFO_ARB_STATS_EN
    ,
    output logic [15:0]                     stall_cnt,
    output logic [15:0]                     grant_cnt
`endif
);

    localparam int unsigned IDW  = $clog2(NUM_REQ);
    localparam int unsigned BCW  = $clog2(MAX_BURST) + 1;
    localparam int unsigned NREQ = NUM_REQ;
    localparam int unsigned DW   = DATA_WIDTH;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]            state;
    logic [IDW-1:0]        owner;
    logic [IDW-1:0]        last_owner;
    logic [BCW-1:0]        beat_cnt;

    logic                  accept;
    logic                  pick_found;
    logic [IDW-1:0]        pick_idx;
    logic [DATA_WIDTH-1:0] beat [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            beat[i] = req_data[i*DW +: DW];
        end
    end

    assign accept   = (state == GRANT) && req_valid[owner] && !wfull && !wrst;
    assign winc     = accept;
    assign busy     = (state == GRANT);
    assign grant_id = owner;
    assign wdata    = (state == GRANT) ? beat[owner] : '0;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (IDW'(i) == owner);
        end
    end

    // Rotating search starting just after the previous owner.
    always_comb begin
        int unsigned cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_owner) + k) % NREQ;
            if (!pick_found && req_valid[IDW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDW'(cand);
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDW'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_valid[owner]) begin
                        last_owner <= owner;
                        state      <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + BCW'(1);
                        if (beat_cnt == BCW'(MAX_BURST - 1)) begin
                            last_owner <= owner;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AFIFO_ARB_STATS_EN
    logic stall;
    logic new_grant;

    assign stall     = (state == GRANT) && req_valid[owner] && wfull;
    assign new_grant = (state == IDLE) && pick_found;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (new_grant && (grant_cnt != 16'hFFFF)) begin
                grant_cnt <= grant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter (DATA_WIDTH=32, NUM_REQ=4, MAX_BURST=4).
// Stats checks are compiled in when AFIFO_ARB_STATS_EN is defined.
module tb_afifo_wr_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              wclk = 1'b0;
    logic              wrst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              winc;
    logic [DW-1:0]     wdata;
    logic              wfull;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef AFIFO_ARB_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       grant_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 wclk = ~wclk;

    afifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .winc      (winc),
        .wdata     (wdata),
        .wfull     (wfull),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef AFIFO_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst      = 1'b1;
        req_valid = '0;
        wfull     = 1'b0;
        tick();
        tick();
        wrst = 1'b0;
    endtask

    initial begin
        int sent;
        int wcount;
        int bc [NR];
        logic [3:0] rdy;
        bit exp_w1 [8]  = '{0, 1, 1, 1, 1, 0, 1, 1};
        bit exp_w3 [10] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        bit wf3    [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};

        req_data = '0;
        do_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_winc", winc, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_ready", req_ready, 0);

        // Single requester 2, six beats: 4-beat burst, bubble, 2 beats.
        sent   = 0;
        wcount = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = (sent < 6) ? 4'b0100 : 4'b0000;
            req_data[2*DW +: DW] = 32'hA0 + 32'(sent);
            #1;
            chk("s1_winc", winc, exp_w1[c]);
            if (winc) wcount++;
            if (exp_w1[c]) begin
                chk("s1_wdata", wdata, 32'hA0 + 32'(sent));
                chk("s1_gid", grant_id, 2);
                chk("s1_ready", req_ready, 4'b0100);
            end
            tick();
            if (exp_w1[c]) sent++;
        end
        req_valid = '0;
        #1;
        chk("s1_hold_busy", busy, 1);
        chk("s1_hold_winc", winc, 0);
        tick();
        #1;
        chk("s1_release", busy, 0);
        chk("s1_wcount", 64'(wcount), 6);

        // All four requesting: rotation 0,1,2,3,0 with 4-beat bursts.
        do_reset();
        for (int i = 0; i < NR; i++) bc[i] = 0;
        for (int c = 0; c < 25; c++) begin
            int  g;
            bit  idle;
            req_valid = 4'hF;
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'h100 * (i + 1) + 32'(bc[i]);
            #1;
            idle = (c % 5 == 0);
            g    = (c / 5) % 4;
            chk("s2_busy", busy, !idle);
            chk("s2_winc", winc, !idle);
            if (!idle) begin
                rdy = 4'b0001 << g;
                chk("s2_gid", grant_id, 64'(g));
                chk("s2_ready", req_ready, rdy);
                chk("s2_wdata", wdata, 32'h100 * (g + 1) + 32'(bc[g]));
            end
            tick();
            if (!idle) bc[g]++;
        end

        // Requester 1 stalled by wfull for 5 cycles after its 2nd beat.
        do_reset();
        sent = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = (sent < 4) ? 4'b0010 : 4'b0000;
            req_data[1*DW +: DW] = 32'hB0 + 32'(sent);
            wfull = wf3[c];
            #1;
            chk("s3_winc", winc, exp_w3[c]);
            chk("s3_ready", req_ready, exp_w3[c] ? 4'b0010 : 4'b0000);
            if (c >= 1) begin
                chk("s3_busy", busy, 1);
                chk("s3_gid", grant_id, 1);
            end
            if (exp_w3[c]) chk("s3_wdata", wdata, 32'hB0 + 32'(sent));
            tick();
            if (exp_w3[c]) sent++;
        end
        req_valid = '0;
        wfull     = 1'b0;
        #1;
        chk("s3_release", busy, 0);
`ifdef AFIFO_ARB_STATS_EN
        chk("s3_stall_cnt", stall_cnt, 5);
        chk("s3_grant_cnt", grant_cnt, 1);
`endif

        // Requester 3 drops valid after one beat while requester 0 waits.
        req_valid = 4'b1001;
        req_data[3*DW +: DW] = 32'hC3;
        req_data[0*DW +: DW] = 32'hC0;
        #1;
        chk("s4_idle0", busy, 0);
        tick();
        #1;
        chk("s4_gid3", grant_id, 3);
        chk("s4_winc3", winc, 1);
        chk("s4_ready3", req_ready, 4'b1000);
        chk("s4_wdata3", wdata, 32'hC3);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("s4_drop_busy", busy, 1);
        chk("s4_drop_winc", winc, 0);
        tick();
        #1;
        chk("s4_bubble", busy, 0);
        chk("s4_bubble_winc", winc, 0);
        tick();
        #1;
        chk("s4_gid0", grant_id, 0);
        chk("s4_winc0", winc, 1);
        chk("s4_ready0", req_ready, 4'b0001);
        chk("s4_wdata0", wdata, 32'hC0);
        tick();
        req_valid = '0;
        tick();

        // Reset during requester 1's second beat.
        req_valid = 4'b0010;
        req_data[1*DW +: DW] = 32'hD0;
        #1;
        chk("s5_idle", busy, 0);
        tick();
        #1;
        chk("s5_gid1", grant_id, 1);
        chk("s5_winc1", winc, 1);
        tick();
        wrst = 1'b1;
        #1;
        chk("s5_rst_winc", winc, 0);
        chk("s5_rst_ready", req_ready, 0);
        tick();
        wrst      = 1'b0;
        req_valid = 4'b0011;
        req_data[0*DW +: DW] = 32'hE0;
        #1;
        chk("s5_after_busy", busy, 0);
        chk("s5_after_gid", grant_id, 0);
        chk("s5_after_winc", winc, 0);
        tick();
        #1;
        chk("s5_first_gid", grant_id, 0);
        chk("s5_first_winc", winc, 1);
        chk("s5_first_wdata", wdata, 32'hE0);
        req_valid = '0;
        tick();
        tick();

`ifdef AFIFO_ARB_STATS_EN
        // Long stall saturates the stall counter.
        do_reset();
        req_valid = 4'b0001;
        wfull     = 1'b1;
        repeat (70001) tick();
        #1;
        chk("st_stall_sat", stall_cnt, 16'hFFFF);
        chk("st_grant_one", grant_cnt, 1);
        chk("st_no_winc", winc, 0);
        wfull     = 1'b0;
        req_valid = '0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
